// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared ALU op codes, ID/EX control field positions and bubble constant
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_SLL  = 3'b100,
        ALU_SLT  = 3'b101,
        ALU_RSV6 = 3'b110,
        ALU_RSV7 = 3'b111
    } alu_op_e;

    // ctrl_ex bit positions: wb[8:6], mem[5:4], alu op[3:1], alu src[0]
    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_PC4SEL   = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_OP_HI    = 3;
    localparam int CTRL_OP_LO    = 1;
    localparam int CTRL_ALUSRC   = 0;

    // ctrl_mem bit positions: wb[4:2], mem[1:0]
    localparam int MEM_REGWRITE = 4;
    localparam int MEM_PC4SEL   = 3;
    localparam int MEM_MEMTOREG = 2;

    localparam logic [4:0] CTRL_BUBBLE = 5'b00000;

    function automatic logic [XLEN-1:0] sel_operand_b(input logic alusrc_imm,
                                                      input logic [XLEN-1:0] imm,
                                                      input logic [XLEN-1:0] rs2_val);
        return alusrc_imm ? imm : rs2_val;
    endfunction

endpackage

// File: rtl/ex_alu.sv
// rtl/ex_alu.sv - combinational 32-bit ALU for the EX stage
module ex_alu
    import riscv_pkg::*;
(
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (alu_op_e'(op))
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLL: result = a << b[4:0];
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - EX stage: operand select, ALU, EX/MEM register; optional EX_STAGE_FWD_EN forwarding
module ex_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_ex,
    input  logic [8:0]      ctrl_ex,
    input  logic [XLEN-1:0] pc4_ex,
    input  logic [XLEN-1:0] r_data1,
    input  logic [XLEN-1:0] r_data2,
    input  logic [XLEN-1:0] extended,
    input  logic [XLEN-1:0] rd_ex,
    input  logic            stall,
    input  logic            flush,
`ifdef EX_STAGE_FWD_EN
    input  logic [4:0]      rs1_ex,
    input  logic [4:0]      rs2_ex,
    input  logic            op_write,
    input  logic [XLEN-1:0] write_addr,
    input  logic [XLEN-1:0] write_data,
`endif
    output logic [XLEN-1:0] alu_result_mem,
    output logic [XLEN-1:0] w_data_mem,
    output logic [XLEN-1:0] pc4_mem,
    output logic [4:0]      ctrl_mem,
    output logic [XLEN-1:0] rd_mem,
    output logic            valid_mem
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic            unused_rd_hi;

    assign unused_rd_hi = ^rd_ex[XLEN-1:5];

`ifdef EX_STAGE_FWD_EN
    logic            mem_fwd_ok;
    logic [XLEN-1:0] mem_fwd_val;
    logic            unused_wa_hi;

    assign unused_wa_hi = ^write_addr[XLEN-1:5];

    // A load in MEM has no value yet, so only non-memtoreg writers forward from MEM
    assign mem_fwd_ok  = valid_mem && ctrl_mem[MEM_REGWRITE] && !ctrl_mem[MEM_MEMTOREG];
    assign mem_fwd_val = ctrl_mem[MEM_PC4SEL] ? pc4_mem : alu_result_mem;

    always_comb begin
        op_a = r_data1;
        if (rs1_ex != 5'd0) begin
            if (mem_fwd_ok && (rd_mem[4:0] == rs1_ex))
                op_a = mem_fwd_val;
            else if (op_write && (write_addr[4:0] == rs1_ex))
                op_a = write_data;
        end
    end

    always_comb begin
        rs2_val = r_data2;
        if (rs2_ex != 5'd0) begin
            if (mem_fwd_ok && (rd_mem[4:0] == rs2_ex))
                rs2_val = mem_fwd_val;
            else if (op_write && (write_addr[4:0] == rs2_ex))
                rs2_val = write_data;
        end
    end
`else
    assign op_a    = r_data1;
    assign rs2_val = r_data2;
`endif

    assign op_b = sel_operand_b(ctrl_ex[CTRL_ALUSRC], extended, rs2_val);

    ex_alu u_alu (
        .op     (ctrl_ex[CTRL_OP_HI:CTRL_OP_LO]),
        .a      (op_a),
        .b      (op_b),
        .result (alu_result)
    );

    // Priority: reset, flush, stall, then load (an invalid load is a bubble)
    always_ff @(posedge clk) begin
        if (reset || flush || (!stall && !valid_ex)) begin
            alu_result_mem <= '0;
            w_data_mem     <= '0;
            pc4_mem        <= '0;
            ctrl_mem       <= CTRL_BUBBLE;
            rd_mem         <= '0;
            valid_mem      <= 1'b0;
        end else if (!stall) begin
            alu_result_mem <= alu_result;
            w_data_mem     <= rs2_val;
            pc4_mem        <= pc4_ex;
            ctrl_mem       <= ctrl_ex[CTRL_REGWRITE:CTRL_MEMWRITE];
            rd_mem         <= {{(XLEN-5){1'b0}}, rd_ex[4:0]};
            valid_mem      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed scoreboard bench for ex_stage
module tb_ex_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  ctrl;
        logic [31:0] rd;
        logic        valid;
    } out_t;

    logic        clk = 1'b0;
    logic        reset, valid_ex, stall, flush;
    logic [8:0]  ctrl_ex;
    logic [31:0] pc4_ex, r_data1, r_data2, extended, rd_ex;
    logic [31:0] alu_result_mem, w_data_mem, pc4_mem, rd_mem;
    logic [4:0]  ctrl_mem;
    logic        valid_mem;
`ifdef EX_STAGE_FWD_EN
    logic [4:0]  rs1_ex, rs2_ex;
    logic        op_write;
    logic [31:0] write_addr, write_data;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    out_t sb[$];
    out_t last_exp;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk            (clk),
        .reset          (reset),
        .valid_ex       (valid_ex),
        .ctrl_ex        (ctrl_ex),
        .pc4_ex         (pc4_ex),
        .r_data1        (r_data1),
        .r_data2        (r_data2),
        .extended       (extended),
        .rd_ex          (rd_ex),
        .stall          (stall),
        .flush          (flush),
`ifdef EX_STAGE_FWD_EN
        .rs1_ex         (rs1_ex),
        .rs2_ex         (rs2_ex),
        .op_write       (op_write),
        .write_addr     (write_addr),
        .write_data     (write_data),
`endif
        .alu_result_mem (alu_result_mem),
        .w_data_mem     (w_data_mem),
        .pc4_mem        (pc4_mem),
        .ctrl_mem       (ctrl_mem),
        .rd_mem         (rd_mem),
        .valid_mem      (valid_mem)
    );

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] wide;
        case (op)
            3'd0: begin wide = {1'b0, a} + {1'b0, b}; return wide[31:0]; end
            3'd1: begin wide = {1'b0, a} + {1'b0, ~b} + 33'd1; return wide[31:0]; end
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a << b[4:0];
            3'd5: begin
                if (a[31] != b[31]) return {31'd0, a[31]};
                return {31'd0, a < b};
            end
            default: return 32'd0;
        endcase
    endfunction

    // Push an expectation, clock once, pop and compare against the registered outputs
    task automatic cycle_exp(input string tag, input out_t e);
        out_t got, want;
        sb.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
        want = sb.pop_front();
        got  = {alu_result_mem, w_data_mem, pc4_mem, ctrl_mem, rd_mem, valid_mem};
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic cycle(input string tag);
        out_t e;
        if (reset || flush || (!stall && !valid_ex)) e = '0;
        else if (stall) e = last_exp;
        else begin
            e.alu   = ref_alu(ctrl_ex[3:1], r_data1, ctrl_ex[0] ? extended : r_data2);
            e.wd    = r_data2;
            e.pc4   = pc4_ex;
            e.ctrl  = ctrl_ex[8:4];
            e.rd    = {27'd0, rd_ex[4:0]};
            e.valid = 1'b1;
        end
        cycle_exp(tag, e);
    endtask

    task automatic spot(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic drive(input logic [8:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc4, input logic [31:0] rd);
        ctrl_ex = c; r_data1 = a; r_data2 = b; extended = imm; pc4_ex = pc4; rd_ex = rd;
    endtask

    initial begin
        last_exp = '0;
        reset = 1'b1; valid_ex = 1'b1; stall = 1'b0; flush = 1'b0;
`ifdef EX_STAGE_FWD_EN
        rs1_ex = 5'd0; rs2_ex = 5'd0; op_write = 1'b0; write_addr = '0; write_data = '0;
`endif
        drive(9'b100_00_0001, 32'h11, 32'h22, 32'h33, 32'h44, 32'd9);
        #1;
        cycle("reset_state");
        reset = 1'b0;

        drive(9'b100_00_0001, 32'd8, 32'h55, 32'd7, 32'd404, 32'd12);
        cycle("addi");
        spot("addi_alu", alu_result_mem, 32'd15);
        spot("addi_ctrl", {27'd0, ctrl_mem}, 32'b10000);
        spot("addi_rd", rd_mem, 32'd12);

        drive(9'b100_00_1010, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd8, 32'd3);
        cycle("slt_neg");
        spot("slt_neg_alu", alu_result_mem, 32'd1);
        drive(9'b100_00_1010, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd12, 32'd3);
        cycle("slt_swap");
        spot("slt_swap_alu", alu_result_mem, 32'd0);

        drive(9'b000_01_0001, 32'd100, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'd16, 32'd0);
        cycle("sd");
        spot("sd_alu", alu_result_mem, 32'd96);
        spot("sd_wdata", w_data_mem, 32'hDEAD_BEEF);
        spot("sd_ctrl", {27'd0, ctrl_mem}, 32'b00001);

        // every op, including wraparound and shift amount taken from B[4:0]
        for (int op = 0; op < 8; op++) begin
            drive({3'b110, 2'b10, op[2:0], 1'b0}, 32'hF0F0_00FF, 32'h0000_0025, 32'd0, 32'h200 + op, 32'hFFFF_FFE0 | op);
            cycle($sformatf("op%0d", op));
        end
        drive(9'b100_00_0000, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd4, 32'd1);
        cycle("add_wrap");
        spot("add_wrap_alu", alu_result_mem, 32'd1);
        drive(9'b100_00_0010, 32'd0, 32'd1, 32'd0, 32'd4, 32'd1);
        cycle("sub_wrap");
        spot("sub_wrap_alu", alu_result_mem, 32'hFFFF_FFFF);

        valid_ex = 1'b0;
        drive(9'b111_11_0110, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9);
        cycle("invalid_bubble");
        valid_ex = 1'b1;

        drive(9'b101_00_0111, 32'h1234, 32'h00F0, 32'h0F0F, 32'h300, 32'd21);
        cycle("pre_stall");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(9'b010_10_0000 + i, 32'h9 + i, 32'h77, 32'h3, 32'h900 + i, 32'd2 + i);
            cycle($sformatf("stall%0d", i));
        end
        flush = 1'b1;
        cycle("stall_flush");
        spot("stall_flush_valid", {31'd0, valid_mem}, 32'd0);
        stall = 1'b0; flush = 1'b0;

        drive(9'b100_00_0011, 32'h3, 32'h4, 32'd0, 32'h40, 32'd6);
        cycle("reload");
        flush = 1'b1;
        cycle("flush_only");
        flush = 1'b0;
        cycle("after_flush");
        stall = 1'b1; flush = 1'b1; reset = 1'b1;
        cycle("reset_mid_stream");
        stall = 1'b0; flush = 1'b0; reset = 1'b0;

`ifdef EX_STAGE_FWD_EN
        drive(9'b100_00_0000, 32'd12, 32'd8, 32'd0, 32'h100, 32'd5);
        cycle_exp("fwd_producer", '{alu: 32'd20, wd: 32'd8, pc4: 32'h100, ctrl: 5'b10000, rd: 32'd5, valid: 1'b1});
        drive(9'b100_00_0000, 32'd0, 32'd3, 32'd0, 32'h104, 32'd7);
        rs1_ex = 5'd5; op_write = 1'b1; write_addr = 32'd5; write_data = 32'd9;
        cycle_exp("fwd_mem_beats_wb", '{alu: 32'd23, wd: 32'd3, pc4: 32'h104, ctrl: 5'b10000, rd: 32'd7, valid: 1'b1});
        drive(9'b100_00_0000, 32'd1, 32'd0, 32'd0, 32'h108, 32'd8);
        rs1_ex = 5'd1; rs2_ex = 5'd6; write_addr = 32'd6; write_data = 32'h40;
        cycle_exp("fwd_wb_rs2", '{alu: 32'h41, wd: 32'h40, pc4: 32'h108, ctrl: 5'b10000, rd: 32'd8, valid: 1'b1});
        drive(9'b100_00_0000, 32'd2, 32'd3, 32'd0, 32'h10C, 32'd0);
        rs1_ex = 5'd0; rs2_ex = 5'd0; write_addr = 32'd0; write_data = 32'h99;
        cycle_exp("fwd_x0_never", '{alu: 32'd5, wd: 32'd3, pc4: 32'h10C, ctrl: 5'b10000, rd: 32'd0, valid: 1'b1});
        op_write = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
